// File: rtl/audio_route_fader.sv
// audio_route_fader: selects one of NUM_SRC multichannel PCM sources with frame-aligned gain-ramped switching.
// Optional build macro AUDIO_ROUTE_PEAK_EN adds per-channel peak magnitude tracking (peak_clr / peak_abs).
module audio_route_fader #(
    parameter int NUM_SRC = 4,
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 24,
    parameter int SEL_W   = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             run,
    input  logic [SEL_W-1:0]                 select,
    input  logic [7:0]                       ramp_step,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC*NUM_CH*DATA_W-1:0] src_data,
    output logic                             dout_valid,
    output logic [NUM_CH*DATA_W-1:0]         dout_data,
    output logic [SEL_W-1:0]                 active_sel,
    output logic                             switching
`ifdef AUDIO_ROUTE_PEAK_EN
    ,
    input  logic                             peak_clr,
    output logic [NUM_CH*(DATA_W-1)-1:0]     peak_abs
`endif
);

    localparam int          FW    = NUM_CH * DATA_W;
    localparam logic [16:0] UNITY = 17'h10000;

    typedef enum logic [1:0] {IDLE, PLAY, FADE_OUT, FADE_IN} state_t;

    state_t             r_state, w_next_state;
    logic [16:0]        r_gain, w_next_gain;
    logic [SEL_W-1:0]   r_active_sel, w_next_active;
    logic [SEL_W-1:0]   r_pending, w_next_pending;
    logic               r_switching;
    logic               r_s1_valid;
    logic [FW-1:0]      r_s1_data;
    logic [16:0]        r_s1_gain;
    logic               r_dout_valid;
    logic [FW-1:0]      r_dout_data;
    logic               w_acc;
    logic [FW-1:0]      w_frame;
    logic [16:0]        w_step, w_down, w_up;
    logic [17:0]        w_up_sum;
    logic               w_sel_ok, w_sel_new;
    logic [DATA_W+17:0] w_prod [NUM_CH];
    logic [FW-1:0]      w_scaled;

    // A zero step behaves as a full-scale step so a fade can never stall
    assign w_step    = (ramp_step == 8'd0) ? UNITY : {9'd0, ramp_step};
    assign w_down    = (r_gain > w_step) ? r_gain - w_step : 17'd0;
    assign w_up_sum  = {1'b0, r_gain} + {1'b0, w_step};
    assign w_up      = (w_up_sum >= {1'b0, UNITY}) ? UNITY : w_up_sum[16:0];
    assign w_sel_ok  = 32'(select) < NUM_SRC;
    assign w_sel_new = w_sel_ok && (select != r_active_sel);

    // Source mux, next state and gain update for the accepted frame
    always_comb begin
        w_next_state   = r_state;
        w_next_gain    = r_gain;
        w_next_active  = r_active_sel;
        w_next_pending = r_pending;
        w_acc          = 1'b0;
        w_frame        = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (SEL_W'(s) == r_active_sel) begin
                w_acc   = src_valid[s];
                w_frame = src_data[s*FW +: FW];
            end
        end
        case (r_state)
            IDLE: w_next_state = PLAY;
            PLAY: begin
                if (w_sel_new) begin
                    if (ramp_step == 8'd0) begin
                        if (w_acc) w_next_active = select;
                    end else begin
                        w_next_state   = FADE_OUT;
                        w_next_pending = select;
                    end
                end
            end
            FADE_OUT: begin
                if (w_acc) w_next_gain = w_down;
                if (w_sel_ok) w_next_pending = select;
                if (w_sel_ok && select == r_active_sel) begin
                    w_next_state = FADE_IN;
                end else if (w_acc && w_down == 17'd0) begin
                    w_next_state  = FADE_IN;
                    w_next_active = w_sel_ok ? select : r_pending;
                end
            end
            FADE_IN: begin
                if (w_acc) w_next_gain = w_up;
                if (w_sel_new) begin
                    w_next_state   = FADE_OUT;
                    w_next_pending = select;
                end else if (w_acc && w_up == UNITY) begin
                    w_next_state = PLAY;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Control state register; run low parks in IDLE at unity gain and tracks the requested source
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_gain       <= UNITY;
            r_active_sel <= '0;
            r_pending    <= '0;
            r_switching  <= 1'b0;
        end else if (!run) begin
            r_state     <= IDLE;
            r_gain      <= UNITY;
            r_switching <= 1'b0;
            if (w_sel_ok) r_active_sel <= select;
        end else begin
            r_state      <= w_next_state;
            r_gain       <= w_next_gain;
            r_active_sel <= w_next_active;
            r_pending    <= w_next_pending;
            r_switching  <= (w_next_state == FADE_OUT) || (w_next_state == FADE_IN);
        end
    end

    // Signed sample times unsigned gain, arithmetic shift by 16 (floor)
    always_comb begin
        w_scaled = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_prod[c] = {{18{r_s1_data[c*DATA_W+DATA_W-1]}}, r_s1_data[c*DATA_W +: DATA_W]}
                      * {{(DATA_W+1){1'b0}}, r_s1_gain};
            w_scaled[c*DATA_W +: DATA_W] = w_prod[c][DATA_W+15:16];
        end
    end

    // Two-stage datapath: capture frame with post-update gain, then register scaled output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_gain    <= UNITY;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else if (!run) begin
            r_s1_valid   <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else begin
            r_s1_valid   <= w_acc;
            r_dout_valid <= r_s1_valid;
            if (w_acc) begin
                r_s1_data <= w_frame;
                r_s1_gain <= w_next_gain;
            end
            if (r_s1_valid) r_dout_data <= w_scaled;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_data  = r_dout_data;
    assign active_sel = r_active_sel;
    assign switching  = r_switching;

`ifdef AUDIO_ROUTE_PEAK_EN
    logic [NUM_CH*(DATA_W-1)-1:0] r_peak, w_peak_next;
    logic [DATA_W-1:0]            w_pk_smp [NUM_CH];
    logic [DATA_W-1:0]            w_pk_neg [NUM_CH];
    logic [DATA_W-2:0]            w_pk_abs [NUM_CH];

    // Per-channel magnitude of the output frame; the most negative code saturates
    always_comb begin
        w_peak_next = r_peak;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pk_smp[c] = r_dout_data[c*DATA_W +: DATA_W];
            w_pk_neg[c] = -w_pk_smp[c];
            w_pk_abs[c] = !w_pk_smp[c][DATA_W-1] ? w_pk_smp[c][DATA_W-2:0]
                        : (w_pk_neg[c][DATA_W-1] ? '1 : w_pk_neg[c][DATA_W-2:0]);
            if (w_pk_abs[c] > r_peak[c*(DATA_W-1) +: DATA_W-1])
                w_peak_next[c*(DATA_W-1) +: DATA_W-1] = w_pk_abs[c];
        end
    end

    // Peak hold register; clear takes priority over a same-cycle update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_peak <= '0;
        else if (peak_clr)     r_peak <= '0;
        else if (r_dout_valid) r_peak <= w_peak_next;
    end

    assign peak_abs = r_peak;
`endif

endmodule

// File: tb/tb_audio_route_fader.sv
// tb_audio_route_fader: scoreboard bench for audio_route_fader (optional AUDIO_ROUTE_PEAK_EN section)
module tb_audio_route_fader;
    localparam int NS = 4;
    localparam int NC = 2;
    localparam int DW = 24;
    localparam int SW = 3;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                run = 1'b0;
    logic [SW-1:0]       select = '0;
    logic [7:0]          ramp_step = '0;
    logic [NS-1:0]       src_valid = '0;
    logic [NS*NC*DW-1:0] src_data = '0;
    logic                dout_valid;
    logic [NC*DW-1:0]    dout_data;
    logic [SW-1:0]       active_sel;
    logic                switching;
`ifdef AUDIO_ROUTE_PEAK_EN
    logic                peak_clr = 1'b0;
    logic [NC*(DW-1)-1:0] peak_abs;
`endif

    audio_route_fader #(.NUM_SRC(NS), .NUM_CH(NC), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .select(select), .ramp_step(ramp_step),
        .src_valid(src_valid), .src_data(src_data), .dout_valid(dout_valid), .dout_data(dout_data),
        .active_sel(active_sel), .switching(switching)
`ifdef AUDIO_ROUTE_PEAK_EN
        , .peak_clr(peak_clr), .peak_abs(peak_abs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {int t; logic [NC*DW-1:0] d;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output strobe must match the oldest expected frame and its cycle
    always @(negedge clk) begin
        exp_t e;
        if (dout_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got %h at cycle %0d expected no output", dout_data, cyc);
            end else begin
                e = q.pop_front();
                if (dout_data !== e.d || cyc != e.t) begin
                    errors++;
                    $display("FAIL frame: got %h at cycle %0d expected %h at cycle %0d", dout_data, cyc, e.d, e.t);
                end
            end
        end
    end

    task automatic idle(input int n);
        src_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int s, input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input logic [DW-1:0] el, input logic [DW-1:0] er, input bit ex);
        src_valid = '0;
        src_valid[s] = 1'b1;
        src_data[(s*NC)*DW +: DW] = l;
        src_data[(s*NC+1)*DW +: DW] = r;
        if (ex) q.push_back('{t: cyc + 2, d: {er, el}});
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        #2 reset_n = 1'b0;
        #1;
        check("reset_valid", dout_valid, 0);
        check("reset_data", dout_data, 0);
        check("reset_switching", switching, 0);
        check("reset_active", active_sel, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        idle(2);

        // passthrough at unity gain
        send(0, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 1);
        idle(3);
        check("t1_active", active_sel, 0);

        // foreign strobes ignored, out-of-range select ignored
        send(1, 24'h0F0F0F, 24'h0E0E0E, 0, 0, 0);
        send(0, 24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 1);
        send(1, 24'h0F0F0F, 24'h0E0E0E, 0, 0, 0);
        send(0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1);
        ramp_step = 8'd64;
        select = 3'd5;
        idle(3);
        check("sel5_switching", switching, 0);
        check("sel5_active", active_sel, 0);
        send(0, 24'h111111, 24'h222222, 24'h111111, 24'h222222, 1);
        idle(3);

        // fade halfway toward src1 then reverse back to src0
        select = 3'd1;
        idle(1);
        check("t3_fadeout_sw", switching, 1);
        for (int k = 1; k <= 512; k++) begin
            g = 65536 - 64 * k;
            send(0, 24'h400000, 24'hC00000, DW'(64 * g), DW'(-64 * g), 1);
        end
        select = 3'd0;
        idle(1);
        check("t3_reverse_sw", switching, 1);
        check("t3_reverse_active", active_sel, 0);
        for (int j = 1; j <= 512; j++) begin
            g = 32768 + 64 * j;
            send(0, 24'h400000, 24'hC00000, DW'(64 * g), DW'(-64 * g), 1);
            if (j == 511) check("t3_still_fading", switching, 1);
        end
        check("t3_done_sw", switching, 0);
        check("t3_done_active", active_sel, 0);
        idle(3);

        // full fade src0 -> src1
        select = 3'd1;
        idle(1);
        check("t2_fadeout_sw", switching, 1);
        for (int k = 1; k <= 1024; k++) begin
            g = 65536 - 64 * k;
            if (k == 100) send(1, 24'h0A0A0A, 24'h0B0B0B, 0, 0, 0);
            send(0, 24'h400000, 24'hC00000, DW'(64 * g), DW'(-64 * g), 1);
        end
        idle(1);
        check("t2_swap_active", active_sel, 1);
        check("t2_swap_sw", switching, 1);
        for (int j = 1; j <= 1024; j++) begin
            send(1, 24'h200000, 24'h100000, DW'(2048 * j), DW'(1024 * j), 1);
            if (j == 1023) check("t2_still_fading", switching, 1);
        end
        check("t2_done_sw", switching, 0);
        check("t2_done_active", active_sel, 1);
        idle(3);

        // async reset mid-fade drops in-flight frame
        select = 3'd0;
        idle(1);
        for (int k = 1; k <= 10; k++) begin
            g = 65536 - 64 * k;
            send(1, 24'h200000, 24'h100000, DW'(32 * g), DW'(16 * g), 1);
        end
        send(1, 24'h200000, 24'h100000, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", dout_valid, 0);
        check("rst_mid_data", dout_data, 0);
        check("rst_mid_switching", switching, 0);
        check("rst_mid_active", active_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        send(0, 24'h123456, 24'h654321, 24'h123456, 24'h654321, 1);
        idle(3);

        // run low mid-fade flushes and tracks select
        select = 3'd1;
        idle(1);
        for (int k = 1; k <= 10; k++) begin
            g = 65536 - 64 * k;
            send(0, 24'h400000, 24'hC00000, DW'(64 * g), DW'(-64 * g), 1);
        end
        send(0, 24'h400000, 24'hC00000, 0, 0, 0);
        #1 run = 1'b0;
        src_valid = '0;
        @(negedge clk);
        check("run0_valid", dout_valid, 0);
        check("run0_data", dout_data, 0);
        check("run0_switching", switching, 0);
        check("run0_active", active_sel, 1);
        run = 1'b1;
        idle(2);
        send(1, 24'h0ABCDE, 24'h7FFFFF, 24'h0ABCDE, 24'h7FFFFF, 1);
        idle(3);

`ifdef AUDIO_ROUTE_PEAK_EN
        peak_clr = 1'b1;
        idle(1);
        peak_clr = 1'b0;
        send(1, 24'h800000, 24'h100000, 24'h800000, 24'h100000, 1);
        idle(3);
        check("peak_sat", peak_abs, {23'h100000, 23'h7FFFFF});
        send(1, 24'h000010, 24'h000010, 24'h000010, 24'h000010, 1);
        idle(1);
        peak_clr = 1'b1;
        idle(1);
        peak_clr = 1'b0;
        check("peak_clr_wins", peak_abs, 0);
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
